// File: rtl/hotlist_merge.sv
// Hot-address list: merges repeat addresses into existing entries, queues new
// ones in a circular buffer, and hands them out one per cycle through an output register.
module hotlist_merge #(
    parameter int ADDR_SIZE     = 21,
    parameter int CNT_SIZE      = 12,
    parameter int LIST_SIZE     = 32,
    parameter int DROP_OLDEST   = 0,
    parameter int DROP_CNT_SIZE = 16,
    localparam int PTR_WIDTH    = $clog2(LIST_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_SIZE-1:0]          input_addr,
    input  logic [CNT_SIZE-1:0]           input_cnt,
    input  logic                          input_valid,
    input  logic [CNT_SIZE-1:0]           threshold,
    input  logic                          flush,
    input  logic                          query_en,
    output logic                          query_ready,
    output logic                          mig_addr_cnt_ready,
    output logic [ADDR_SIZE+CNT_SIZE-1:0] mig_addr_cnt,
    input  logic                          mig_addr_cnt_en,
    output logic [PTR_WIDTH:0]            occupancy,
    output logic [DROP_CNT_SIZE-1:0]      drop_count
);

    typedef logic [PTR_WIDTH-1:0] ptr_t;

    localparam ptr_t                     PTR_LAST = ptr_t'(LIST_SIZE - 1);
    localparam ptr_t                     PTR_ONE  = ptr_t'(1);
    localparam logic [PTR_WIDTH:0]       CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0]       CNT_FULL = (PTR_WIDTH+1)'(LIST_SIZE);
    localparam logic [DROP_CNT_SIZE-1:0] DROP_ONE = DROP_CNT_SIZE'(1);

    logic [ADDR_SIZE-1:0]          addr_mem [LIST_SIZE];
    logic [CNT_SIZE-1:0]           cnt_mem  [LIST_SIZE];
    logic [LIST_SIZE-1:0]          vld;
    ptr_t                          rd_ptr;
    ptr_t                          wr_ptr;
    logic [PTR_WIDTH:0]            count;
    logic                          out_valid;
    logic [ADDR_SIZE+CNT_SIZE-1:0] out_data;
    logic [DROP_CNT_SIZE-1:0]      drops;

    logic accept, full, pop, match_hit, merge, push, overwrite, drop, write;
    ptr_t match_idx;
    logic [CNT_SIZE:0]   sum;
    logic [CNT_SIZE-1:0] merged_cnt;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == PTR_LAST) ? '0 : p + PTR_ONE;
    endfunction

    // Output handshake: the register holds data while mig_addr_cnt_ready=1 and is
    // consumed at any edge where mig_addr_cnt_en=1; a pop (query_en && query_ready)
    // refills it at that same edge, so entries can stream out one per cycle.
    assign accept      = input_valid && (input_cnt >= threshold) && !flush;
    assign full        = (count == CNT_FULL);
    assign query_ready = !rst && !flush && (count != '0) && (!out_valid || mig_addr_cnt_en);
    assign pop         = query_en && query_ready;

    // The entry leaving this cycle is excluded so a re-hot address becomes a new entry.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = 0; i < LIST_SIZE; i++) begin
            if (vld[i] && (addr_mem[i] == input_addr) && !(pop && (ptr_t'(i) == rd_ptr))) begin
                match_hit = 1'b1;
                match_idx = ptr_t'(i);
            end
        end
    end

    assign merge      = accept && match_hit;
    assign push       = accept && !match_hit && (!full || pop);
    assign drop       = accept && !match_hit && full && !pop;
    assign overwrite  = drop && (DROP_OLDEST != 0);
    assign write      = push || overwrite;
    assign sum        = {1'b0, cnt_mem[match_idx]} + {1'b0, input_cnt};
    assign merged_cnt = sum[CNT_SIZE] ? '1 : sum[CNT_SIZE-1:0];

    // Entry payloads carry no reset; vld decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (write) begin
                addr_mem[wr_ptr] <= input_addr;
                cnt_mem[wr_ptr]  <= input_cnt;
            end else if (merge) begin
                cnt_mem[match_idx] <= merged_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            vld       <= '0;
            drops     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                vld    <= '0;
            end else begin
                if (pop) begin
                    rd_ptr      <= ptr_inc(rd_ptr);
                    vld[rd_ptr] <= 1'b0;
                end
                if (overwrite) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                // Set after the pop clear: when full, push and pop share a slot.
                if (write) begin
                    wr_ptr      <= ptr_inc(wr_ptr);
                    vld[wr_ptr] <= 1'b1;
                end
                if (push && !pop) begin
                    count <= count + CNT_ONE;
                end else if (pop && !push) begin
                    count <= count - CNT_ONE;
                end
            end
            if (drop && (drops != '1)) begin
                drops <= drops + DROP_ONE;
            end
            if (pop) begin
                out_data  <= {addr_mem[rd_ptr], cnt_mem[rd_ptr]};
                out_valid <= 1'b1;
            end else if (mig_addr_cnt_en) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign mig_addr_cnt_ready = out_valid;
    assign mig_addr_cnt       = out_data;
    assign occupancy          = count;
    assign drop_count         = drops;

endmodule

// File: doc/hotlist_merge.md
HOTLIST_MERGE -- requirements
Module: hotlist_merge

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_SIZE, 21, address width.
- CNT_SIZE, 12, count width.
- LIST_SIZE, 32, entry depth, >=2.
- DROP_OLDEST, 0: 0 = drop the incoming entry when full; 1 = overwrite the oldest entry.
- DROP_CNT_SIZE, 16, drop counter width.

REQ-002 PTR_WIDTH SHALL be clog2(LIST_SIZE).

REQ-003 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; one clock, all logic on its rising edge.
- rst, in, 1, reset; synchronous, active-high.
- input_addr, in, ADDR_SIZE, candidate address.
- input_cnt, in, CNT_SIZE, candidate access count.
- input_valid, in, 1, candidate present this cycle.
- threshold, in, CNT_SIZE, minimum input_cnt for acceptance.
- flush, in, 1, discard all stored entries.
- query_en, in, 1, consumer requests a pop.
- query_ready, out, 1, pop possible this cycle.
- mig_addr_cnt_ready, out, 1, output register holds valid data.
- mig_addr_cnt, out, ADDR_SIZE+CNT_SIZE, {addr, cnt} of the popped entry.
- mig_addr_cnt_en, in, 1, consumer accepts the output register.
- occupancy, out, PTR_WIDTH+1, number of stored entries.
- drop_count, out, DROP_CNT_SIZE, saturating count of lost entries.

Function
REQ-004 Storage SHALL be a circular buffer with rd_ptr, wr_ptr and count; both pointers wrap from LIST_SIZE-1 to 0.

REQ-005 Accept = input_valid && input_cnt >= threshold && !flush; non-accepted inputs SHALL have no effect and SHALL NOT increment drop_count.

REQ-006 Match = an accepted input_addr equals the addr of any occupied entry, excluding the entry being popped this cycle; at most one match exists because of REQ-007.

REQ-007 On a match, the matched entry's cnt SHALL become min(cnt+input_cnt, 2^CNT_SIZE-1); no push occurs; entry order is unchanged.

REQ-008 Accepted without match and not full (or full with a pop this cycle): push at wr_ptr, wr_ptr++, count++ (count unchanged if a pop also occurs).

REQ-009 Accepted without match, full, no pop:
- DROP_OLDEST=0: discard the input, drop_count++.
- DROP_OLDEST=1: write at wr_ptr, advance both pointers, count unchanged, drop_count++.

REQ-010 drop_count SHALL saturate at all-ones.

REQ-011 query_ready = !flush && count!=0 && (!mig_addr_cnt_ready || mig_addr_cnt_en), combinational.

REQ-012 Pop = query_en && query_ready: the output register SHALL load the entry at rd_ptr next edge, rd_ptr++, count--, and mig_addr_cnt_ready=1.

REQ-013 mig_addr_cnt_ready && mig_addr_cnt_en without pop: mig_addr_cnt_ready SHALL clear next cycle. With pop in the same cycle: it stays 1 and carries the new entry (back-to-back, one entry per cycle).

REQ-014 mig_addr_cnt SHALL hold stable while mig_addr_cnt_ready=1 and mig_addr_cnt_en=0.

REQ-015 Latency:
- An accepted push SHALL be visible in occupancy and query_ready on the next cycle.
- A merge SHALL be visible to a pop on the next cycle.

REQ-016 Flush SHALL take priority over push, merge and pop in the same cycle:
- pointers and count SHALL go to 0 next cycle;
- the output register and drop_count SHALL be unaffected.

REQ-017 The output register SHALL never be match-compared; a re-hot address already popped SHALL be pushed as new.

REQ-018 occupancy SHALL equal count, registered.

Reset
REQ-019 When rst=1 at an edge, the following SHALL clear regardless of other inputs:
- rd_ptr, wr_ptr, count, occupancy, drop_count;
- output register contents, mig_addr_cnt_ready, mig_addr_cnt.

REQ-020 During and after reset query_ready=0 until an accepted push; entry contents need not reset.

REQ-021 Reset asserted mid-operation SHALL discard stored and in-flight entries with no partial output.

Verification
REQ-022 Threshold=8, push addr 0x10 cnt 7 -> occupancy stays 0. Then cnt 8 -> occupancy 1 next cycle.

REQ-023 Push 0x10 cnt 5, then 0x10 cnt 6 -> occupancy 1; pop -> mig_addr_cnt = {0x10, 11}.
- Repeat with cnt 0xFFF -> popped cnt = 0xFFF (saturated).

REQ-024 LIST_SIZE=4, push 0x1..0x5 without pops:
- DROP_OLDEST=0 -> drop_count 1, pops yield 0x1..0x4.
- DROP_OLDEST=1 -> drop_count 1, pops yield 0x2..0x5.

REQ-025 Fill 3 entries, hold query_en=1 and mig_addr_cnt_en=1 -> three consecutive cycles of mig_addr_cnt_ready=1 with entries in order, then ready=0 and query_ready=0.

REQ-026 Full list, same cycle push new addr + pop -> no drop, occupancy unchanged. Flush with push and pop asserted -> occupancy 0 next cycle, no output load, drop_count unchanged.

REQ-027 Wrap test: 3*LIST_SIZE push/pop pairs with distinct addresses -> FIFO order preserved, drop_count 0. Assert rst mid-stream -> all outputs 0 next cycle.
